// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer with one holding register per channel.
// The target channel comes from sel (manual) or from a 2-bit round-robin pointer (auto).
module demux_1to4_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                auto,
  input  logic                ptr_clr,
  input  logic [1:0]          sel,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  output logic [3:0]          m_valid,
  input  logic [3:0]          m_ready,
  output logic [4*DATA_W-1:0] m_data,
  output logic [1:0]          ptr,
  output logic [CNT_W-1:0]    beat_cnt
);

  logic [1:0]        w_target;
  logic              w_accept;
  logic [3:0]        w_load;

  logic [3:0]        r_valid;
  logic [DATA_W-1:0] r_data [4];
  logic [1:0]        r_ptr;
  logic [CNT_W-1:0]  r_cnt;

  // A channel can take a beat when empty or when it drains in this same cycle.
  assign w_target = auto ? r_ptr : sel;
  assign s_ready  = ~r_valid[w_target] | m_ready[w_target];
  assign w_accept = s_valid & s_ready;
  assign w_load   = w_accept ? (4'b0001 << w_target) : 4'b0000;

  // NOTE: the data holding registers are reset too, because m_data must read zero
  // after reset; this is a deliberate choice, not a default for every storage array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= s_data;
        end else if (m_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Clear wins over advance; a beat accepted alongside the clear used the old pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (ptr_clr) begin
      r_ptr <= '0;
    end else if (auto && w_accept) begin
      r_ptr <= r_ptr + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign m_data[g*DATA_W +: DATA_W] = r_data[g];
  end

  assign m_valid  = r_valid;
  assign ptr      = r_ptr;
  assign beat_cnt = r_cnt;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed-vector bench for demux_1to4_stream; a narrow beat counter keeps the wrap
// test short.
module tb_demux_1to4_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                auto;
  logic                ptr_clr;
  logic [1:0]          sel;
  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data;
  logic [3:0]          m_valid;
  logic [3:0]          m_ready;
  logic [4*DATA_W-1:0] m_data;
  logic [1:0]          ptr;
  logic [CNT_W-1:0]    beat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  demux_1to4_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .auto(auto), .ptr_clr(ptr_clr), .sel(sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ptr(ptr), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] chan(input int k);
    return m_data[k*DATA_W +: DATA_W];
  endfunction

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    auto = 1'b0; ptr_clr = 1'b0; sel = 2'd0;
    s_valid = 1'b0; s_data = '0; m_ready = 4'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if (m_valid !== 4'h0 || m_data !== '0 || ptr !== 2'd0 || beat_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_state: m_valid=%h m_data=%h ptr=%0d cnt=%0d, want all 0",
               m_valid, m_data, ptr, beat_cnt);
    end
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_s_ready: got %b want 1", s_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_manual();
    logic [DATA_W-1:0] exp_d [4];
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    m_ready = 4'hF;
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      s_data = exp_d[k];
      #1;
      n_cmp++;
      if (s_ready !== 1'b1) begin
        n_err++;
        $display("FAIL manual_s_ready[%0d]: got %b want 1", k, s_ready);
      end
      tick();
      n_cmp++;
      if (m_valid !== (4'b0001 << k) || chan(k) !== exp_d[k]) begin
        n_err++;
        $display("FAIL manual_beat[%0d]: m_valid=%h data=%h want %h / %h",
                 k, m_valid, chan(k), 4'b0001 << k, exp_d[k]);
      end
    end
    s_valid = 1'b0;
    tick();
    n_cmp++;
    if (m_valid !== 4'h0 || beat_cnt !== 8'd4) begin
      n_err++;
      $display("FAIL manual_end: m_valid=%h cnt=%0d want 0 / 4", m_valid, beat_cnt);
    end
  endtask

  task automatic test_auto_rr();
    auto = 1'b1;
    m_ready = 4'hF;
    s_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_data = 8'(8'h10 + k);
      tick();
      n_cmp++;
      if (m_valid !== (4'b0001 << (k % 4)) || chan(k % 4) !== 8'(8'h10 + k)) begin
        n_err++;
        $display("FAIL auto_beat[%0d]: m_valid=%h data=%h want %h / %h",
                 k, m_valid, chan(k % 4), 4'b0001 << (k % 4), 8'h10 + k);
      end
    end
    s_valid = 1'b0;
    n_cmp++;
    if (ptr !== 2'd2 || beat_cnt !== 8'd6) begin
      n_err++;
      $display("FAIL auto_ptr: ptr=%0d cnt=%0d want 2 / 6", ptr, beat_cnt);
    end
  endtask

  task automatic test_back_to_back();
    sel = 2'd2;
    m_ready = 4'b1011;
    s_valid = 1'b1;
    s_data = 8'h55;
    tick();
    s_data = 8'h66;
    #1;
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 4'b0100 || chan(2) !== 8'h55) begin
      n_err++;
      $display("FAIL stall_hold: s_ready=%b m_valid=%h ch2=%h want 0 / 4 / 55",
               s_ready, m_valid, chan(2));
    end
    tick();
    n_cmp++;
    if (m_valid !== 4'b0100 || chan(2) !== 8'h55 || beat_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL stall_keep: m_valid=%h ch2=%h cnt=%0d want 4 / 55 / 1",
               m_valid, chan(2), beat_cnt);
    end
    m_ready = 4'hF;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL unstall_ready: got %b want 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 4'b0100 || chan(2) !== 8'h66 || beat_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL load_drain: m_valid=%h ch2=%h cnt=%0d want 4 / 66 / 2",
               m_valid, chan(2), beat_cnt);
    end
    tick();
    n_cmp++;
    if (m_valid !== 4'h0 || chan(2) !== 8'h66) begin
      n_err++;
      $display("FAIL drain_keep_data: m_valid=%h ch2=%h want 0 / 66", m_valid, chan(2));
    end
  endtask

  task automatic test_independent();
    sel = 2'd1;
    m_ready = 4'b1101;
    s_valid = 1'b1;
    s_data = 8'h44;
    tick();
    sel = 2'd3;
    s_data = 8'h77;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL retarget_ready: got %b want 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 4'b1010 || chan(3) !== 8'h77 || chan(1) !== 8'h44) begin
      n_err++;
      $display("FAIL retarget_load: m_valid=%h ch3=%h ch1=%h want a / 77 / 44",
               m_valid, chan(3), chan(1));
    end
    tick();
    n_cmp++;
    if (m_valid !== 4'b0010 || chan(1) !== 8'h44) begin
      n_err++;
      $display("FAIL stalled_ch1: m_valid=%h ch1=%h want 2 / 44", m_valid, chan(1));
    end
  endtask

  task automatic test_ptr_clr_wrap();
    auto = 1'b1;
    m_ready = 4'hF;
    s_valid = 1'b1;
    for (int k = 0; k < 255; k++) begin
      s_data = 8'(k);
      tick();
    end
    n_cmp++;
    if (ptr !== 2'd3 || beat_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL pre_clr: ptr=%0d cnt=%h want 3 / ff", ptr, beat_cnt);
    end
    ptr_clr = 1'b1;
    s_data = 8'h5A;
    tick();
    ptr_clr = 1'b0;
    s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 4'b1000 || chan(3) !== 8'h5A) begin
      n_err++;
      $display("FAIL clr_old_ptr: m_valid=%h ch3=%h want 8 / 5a", m_valid, chan(3));
    end
    n_cmp++;
    if (ptr !== 2'd0 || beat_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL clr_wrap: ptr=%0d cnt=%h want 0 / 00", ptr, beat_cnt);
    end
    // auto resumes from ptr 0 after clear
    auto = 1'b0;
    tick();
    auto = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h6B;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 4'b0001 || chan(0) !== 8'h6B || ptr !== 2'd1) begin
      n_err++;
      $display("FAIL resume: m_valid=%h ch0=%h ptr=%0d want 1 / 6b / 1",
               m_valid, chan(0), ptr);
    end
  endtask

  task automatic test_async_reset();
    m_ready = 4'h0;
    auto = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h11;
    tick();
    auto = 1'b0;
    sel = 2'd2;
    s_data = 8'h22;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 4'b0101 || ptr !== 2'd1 || beat_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL pre_rst: m_valid=%h ptr=%0d cnt=%0d want 5 / 1 / 2",
               m_valid, ptr, beat_cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (m_valid !== 4'h0 || m_data !== '0 || ptr !== 2'd0 || beat_cnt !== '0) begin
      n_err++;
      $display("FAIL async_rst: m_valid=%h m_data=%h ptr=%0d cnt=%0d want all 0",
               m_valid, m_data, ptr, beat_cnt);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_manual();
    test_reset();
    test_auto_rr();
    test_reset();
    test_back_to_back();
    test_reset();
    test_independent();
    test_reset();
    test_ptr_clr_wrap();
    test_reset();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
